hazard_ctl: RTL and testbench

Pipeline hazard controller. It consumes the fields that the ID/EX stage register presents (destination register, opcode), the IF/ID source fields, and the EX-stage branch resolution. It drives the write enables and flush controls of the PC, the IF/ID register and the ID/EX register; id_ex_wen connects directly to the ID/EX register write-enable input. It handles load-use stalls, taken-branch flushes, halt draining and external memory stalls, and it keeps saturating stall and flush statistics counters.

---
 rtl/hazard_ctl_if.sv | 30 +++
 rtl/hazard_ctl.sv | 92 +++++++++
 tb/tb_hazard_ctl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctl_if.sv
// hazard_ctl_if: pipeline-register fields in, PC/IF-ID/ID-EX controls out
interface hazard_ctl_if;
    logic [3:0] if_id_rs;
    logic [3:0] if_id_rt;
    logic       if_id_rs_used;
    logic       if_id_rt_used;
    logic [3:0] if_id_op;
    logic [3:0] id_ex_rd;
    logic [3:0] id_ex_op;
    logic       branch_taken;
    logic       ext_stall;
    logic       pc_wen;
    logic       if_id_wen;
    logic       id_ex_wen;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       halted;

    modport master (
        output if_id_rs, if_id_rt, if_id_rs_used, if_id_rt_used, if_id_op,
        output id_ex_rd, id_ex_op, branch_taken, ext_stall,
        input  pc_wen, if_id_wen, id_ex_wen, if_id_flush, id_ex_flush, halted
    );

    modport slave (
        input  if_id_rs, if_id_rt, if_id_rs_used, if_id_rt_used, if_id_op,
        input  id_ex_rd, id_ex_op, branch_taken, ext_stall,
        output pc_wen, if_id_wen, id_ex_wen, if_id_flush, id_ex_flush, halted
    );
endinterface

// File: rtl/hazard_ctl.sv
// hazard_ctl: load-use stall, branch flush, halt drain and memory-stall control with saturating stats
module hazard_ctl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctl_if.slave      bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [3:0] LW         = 4'b1000;
    localparam logic [3:0] HLT        = 4'b1111;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} state_t;

    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       lu, stall_inc, flush_inc;

    // R0 is hard-wired zero, so a load targeting it can never feed a hazard
    assign lu = bus.id_ex_op == LW && bus.id_ex_rd != 4'd0 &&
                ((bus.if_id_rs_used && bus.if_id_rs == bus.id_ex_rd) ||
                 (bus.if_id_rt_used && bus.if_id_rt == bus.id_ex_rd));

    // Next state and pipeline controls; branch redirect outranks everything except freeze and HALT
    always_comb begin
        bus.pc_wen      = 1'b1;
        bus.if_id_wen   = 1'b1;
        bus.id_ex_wen   = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.halted      = !rst && state == HALT;
        state_nx        = state;
        cnt_nx          = cnt;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        if (rst) begin
            state_nx = RUN;
        end else if (bus.ext_stall || state == HALT) begin
            bus.pc_wen    = 1'b0;
            bus.if_id_wen = 1'b0;
            bus.id_ex_wen = 1'b0;
        end else if (bus.branch_taken) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            flush_inc       = 1'b1;
            state_nx        = FLUSH_CYCLES > 1 ? FLUSH : RUN;
            cnt_nx          = FLUSH_CYCLES > 1 ? FLUSH_LOAD : 3'd0;
        end else if (state == FLUSH) begin
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
            flush_inc       = 1'b1;
            cnt_nx          = cnt - 3'd1;
            state_nx        = cnt == 3'd1 ? RUN : FLUSH;
        end else if (state == DRAIN) begin
            bus.pc_wen      = 1'b0;
            bus.if_id_flush = 1'b1;
            cnt_nx          = cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
            state_nx        = cnt == 3'd0 ? HALT : DRAIN;
        end else if (lu) begin
            bus.pc_wen      = 1'b0;
            bus.if_id_wen   = 1'b0;
            bus.id_ex_flush = 1'b1;
            stall_inc       = 1'b1;
        end else if (bus.if_id_op == HLT) begin
            bus.pc_wen = 1'b0;
            state_nx   = DRAIN;
            cnt_nx     = DRAIN_LOAD;
        end
    end

    // State register and saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (stall_inc && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: table-driven check of hazard_ctl plus a CNT_W=2 saturation instance
module tb_hazard_ctl;
    localparam logic [3:0] LW  = 4'b1000;
    localparam logic [3:0] HLT = 4'b1111;

    typedef struct {
        logic       rst;
        logic [3:0] rs, rt;
        logic       rsu, rtu;
        logic [3:0] iop, erd, eop;
        logic       br, xs;
        logic [5:0] o;
        int         st, fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  s_stall, s_flush;
    int          pass = 0;
    int          total = 0;
    vec_t        q[$];

    always #5 clk = ~clk;

    hazard_ctl_if bus ();
    hazard_ctl_if bus2 ();

    hazard_ctl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .bus(bus2), .stall_cnt(s_stall), .flush_cnt(s_flush)
    );

    task automatic add(input logic r, input logic [3:0] rs, rt, input logic rsu, rtu,
                       input logic [3:0] iop, erd, eop, input logic br, xs,
                       input logic [5:0] o, input int st, fl);
        vec_t v;
        v = '{rst: r, rs: rs, rt: rt, rsu: rsu, rtu: rtu, iop: iop, erd: erd, eop: eop,
              br: br, xs: xs, o: o, st: st, fl: fl};
        q.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        bus.if_id_rs = v.rs;   bus2.if_id_rs = v.rs;
        bus.if_id_rt = v.rt;   bus2.if_id_rt = v.rt;
        bus.if_id_rs_used = v.rsu; bus2.if_id_rs_used = v.rsu;
        bus.if_id_rt_used = v.rtu; bus2.if_id_rt_used = v.rtu;
        bus.if_id_op = v.iop;  bus2.if_id_op = v.iop;
        bus.id_ex_rd = v.erd;  bus2.id_ex_rd = v.erd;
        bus.id_ex_op = v.eop;  bus2.id_ex_op = v.eop;
        bus.branch_taken = v.br; bus2.branch_taken = v.br;
        bus.ext_stall = v.xs;  bus2.ext_stall = v.xs;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, exp);
        total++;
        if (act !== exp)
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        else
            pass++;
    endtask

    function automatic int sat3(input int x);
        return x > 3 ? 3 : x;
    endfunction

    initial begin
        // reset, load-use hits and misses
        add(1, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111000, 0, 0);
        add(0, 3, 0, 1, 0, 0,   3, LW, 0, 0, 6'b001010, 1, 0);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111000, 1, 0);
        add(0, 0, 0, 1, 0, 0,   0, LW, 0, 0, 6'b111000, 1, 0);
        add(0, 3, 0, 0, 0, 0,   3, LW, 0, 0, 6'b111000, 1, 0);
        add(0, 0, 5, 0, 1, 0,   5, LW, 0, 0, 6'b001010, 2, 0);
        // branch flush, branch beats load-use, lu ignored in FLUSH
        add(0, 0, 0, 0, 0, 0,   0, 0,  1, 0, 6'b111110, 2, 1);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111110, 2, 2);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111000, 2, 2);
        add(0, 3, 0, 1, 0, 0,   3, LW, 1, 0, 6'b111110, 2, 3);
        add(0, 3, 0, 1, 0, 0,   3, LW, 0, 0, 6'b111110, 2, 4);
        // ext_stall freezes FLUSH with cnt=1
        add(0, 0, 0, 0, 0, 0,   0, 0,  1, 0, 6'b111110, 2, 5);
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 2, 5);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111110, 2, 6);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111000, 2, 6);
        // branch inside FLUSH reloads the counter
        add(0, 0, 0, 0, 0, 0,   0, 0,  1, 0, 6'b111110, 2, 7);
        add(0, 0, 0, 0, 0, 0,   0, 0,  1, 0, 6'b111110, 2, 8);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111110, 2, 9);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111000, 2, 9);
        // HLT drain aborted by an older branch
        add(0, 0, 0, 0, 0, HLT, 0, 0,  0, 0, 6'b011000, 2, 9);
        add(0, 0, 0, 0, 0, 0,   0, 0,  1, 0, 6'b111110, 2, 10);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111110, 2, 11);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111000, 2, 11);
        // HLT drain to HALT, HALT is sticky
        add(0, 0, 0, 0, 0, HLT, 0, 0,  0, 0, 6'b011000, 2, 11);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b011100, 2, 11);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b000001, 2, 11);
        add(0, 0, 0, 0, 0, 0,   0, 0,  1, 0, 6'b000001, 2, 11);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 1, 6'b000001, 2, 11);
        add(0, 3, 0, 1, 0, 0,   3, LW, 0, 0, 6'b000001, 2, 11);
        add(1, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111000, 0, 0);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111000, 0, 0);
        // ext_stall overrides a load-use in RUN
        add(0, 3, 0, 1, 0, 0,   3, LW, 0, 1, 6'b000000, 0, 0);
        add(0, 0, 0, 0, 0, 0,   0, 0,  0, 0, 6'b111000, 0, 0);

        foreach (q[i]) begin
            drive(q[i]);
            #2;
            check("outputs", i, 32'({bus.pc_wen, bus.if_id_wen, bus.id_ex_wen,
                                     bus.if_id_flush, bus.id_ex_flush, bus.halted}), 32'(q[i].o));
            @(posedge clk);
            #1;
            check("counters", i, {stall_cnt, flush_cnt}, {16'(q[i].st), 16'(q[i].fl)});
            check("sat_counters", i, 32'({s_stall, s_flush}),
                  32'({2'(sat3(q[i].st)), 2'(sat3(q[i].fl))}));
        end

        // five back-to-back load-use cycles: the 2-bit counter sticks at 3
        for (int k = 1; k <= 5; k++) begin
            add(0, 3, 0, 1, 0, 0, 3, LW, 0, 0, 6'b001010, k, 0);
            drive(q[$]);
            @(posedge clk);
            #1;
            check("stall_cnt", k, 32'(stall_cnt), 32'(k));
            check("sat_stall", k, 32'(s_stall), 32'(sat3(k)));
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
